// File: rtl/hilo_pipe.sv
// hilo_pipe: HI/LO holder with M/W write slots, EX forwarding and divider handshake; HILO_BYPASS_EN enables forwarding
module hilo_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        flag1_e,
  input  logic [2:0]        flag2_e,
  input  logic              is_div_e,
  input  logic [DATA_W-1:0] hi_wdata_e,
  input  logic [DATA_W-1:0] lo_wdata_e,
  input  logic              div_done,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] hi_e,
  output logic [DATA_W-1:0] lo_e,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_start,
  output logic              div_abort,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic m_v, w_v;
  logic [1:0] m_mask, w_mask;
  logic [DATA_W-1:0] m_hi, m_lo, w_hi, w_lo, hi_r, lo_r;
  logic adv, enter, fsm_stall, hazard;
  assign adv = !stall_i;
  assign enter = flag2_e[2] && !flush_i && !stall_o;
  assign hi_o = hi_r;
  assign lo_o = lo_r;
  assign stall_o = fsm_stall || hazard;
  // M/W write slots shift on advance; W commits into architectural HI/LO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_v <= 1'b0;
      m_mask <= '0;
      m_hi <= '0;
      m_lo <= '0;
      w_v <= 1'b0;
      w_mask <= '0;
      w_hi <= '0;
      w_lo <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else if (adv) begin
      w_v <= m_v;
      w_mask <= m_mask;
      w_hi <= m_hi;
      w_lo <= m_lo;
      m_v <= enter;
      m_mask <= flag2_e[1:0];
      m_hi <= hi_wdata_e;
      m_lo <= lo_wdata_e;
      if (w_v && w_mask[1]) hi_r <= w_hi;
      if (w_v && w_mask[0]) lo_r <= w_lo;
    end
  end
  // divider state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end
  // divider sequencing: launch from IDLE, wait in BUSY, release the held DIV in DONE
  always_comb begin
    state_nx = state;
    div_start = 1'b0;
    div_abort = 1'b0;
    fsm_stall = 1'b0;
    case (state)
      IDLE: if (flag2_e[2] && is_div_e && !flush_i && !stall_i) begin
        div_start = 1'b1;
        fsm_stall = 1'b1;
        state_nx = BUSY;
      end
      BUSY: begin
        fsm_stall = 1'b1;
        div_abort = flush_i;
        state_nx = flush_i ? IDLE : div_done ? DONE : BUSY;
      end
      DONE: state_nx = adv ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
`ifdef HILO_BYPASS_EN
  // newest in-flight write wins per half, then the architectural value
  always_comb begin
    hazard = 1'b0;
    hi_e = (m_v && m_mask[1]) ? m_hi : (w_v && w_mask[1]) ? w_hi : hi_r;
    lo_e = (m_v && m_mask[0]) ? m_lo : (w_v && w_mask[0]) ? w_lo : lo_r;
  end
`else
  // no forwarding: reads of a half with a pending write stall until it commits
  always_comb begin
    hazard = flag1_e[2] && ((m_v && |(m_mask & flag1_e[1:0])) || (w_v && |(w_mask & flag1_e[1:0])));
    hi_e = hi_r;
    lo_e = lo_r;
  end
`endif
endmodule

// File: tb/tb_hilo_pipe.sv
// tb_hilo_pipe: directed scenarios plus randomized stream checked against a pending-write queue model
module tb_hilo_pipe;
  localparam int W = 32;
`ifdef HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, resetn;
  logic [2:0] flag1_e, flag2_e;
  logic is_div_e, div_done, stall_i, flush_i;
  logic [W-1:0] hi_wdata_e, lo_wdata_e, hi_e, lo_e, hi_o, lo_o;
  logic div_start, div_abort, stall_o;
  int n_pass = 0, n_chk = 0;
  typedef struct {
    logic [1:0] mask;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int left;
  } pend_t;
  pend_t q[$];
  logic [W-1:0] mhi, mlo, ehi, elo;
  logic [2:0] cf1, cf2;
  logic [W-1:0] chw, clw;
  logic est, st, fl;
  int n, st_cycles, starts, aborts;

  hilo_pipe #(.DATA_W(W)) dut (
    .clk(clk), .resetn(resetn), .flag1_e(flag1_e), .flag2_e(flag2_e), .is_div_e(is_div_e),
    .hi_wdata_e(hi_wdata_e), .lo_wdata_e(lo_wdata_e), .div_done(div_done), .stall_i(stall_i),
    .flush_i(flush_i), .hi_e(hi_e), .lo_e(lo_e), .hi_o(hi_o), .lo_o(lo_o),
    .div_start(div_start), .div_abort(div_abort), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drv(input logic [2:0] f1, input logic [2:0] f2, input logic dv,
                     input logic [W-1:0] hw, input logic [W-1:0] lw,
                     input logic dd, input logic s, input logic f);
    flag1_e = f1; flag2_e = f2; is_div_e = dv; hi_wdata_e = hw; lo_wdata_e = lw;
    div_done = dd; stall_i = s; flush_i = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic nop;
    drv(3'b000, 3'b000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic new_instr;
    int op;
    op = $urandom_range(0, 5);
    chw = $urandom;
    clw = $urandom;
    cf1 = (op == 4) ? 3'b110 : (op == 5) ? 3'b101 : 3'b000;
    cf2 = (op == 1) ? 3'b110 : (op == 2) ? 3'b101 : (op == 3) ? 3'b111 : 3'b000;
  endtask

  initial begin
    resetn = 1'b1;
    nop();
    #3 resetn = 1'b0;
    #1;
    chk("rst_hi_o", hi_o, 0);
    chk("rst_lo_o", lo_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_start", div_start, 0);
    chk("rst_abort", div_abort, 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    tick(); tick();
    chk("post_rst_hi_o", hi_o, 0);
    chk("post_rst_lo_o", lo_o, 0);
    chk("post_rst_stall", stall_o, 0);
    // MTHI then MFHI
    drv(3'b000, 3'b110, 1'b0, 32'h12345678, '0, 1'b0, 1'b0, 1'b0);
    #1 chk("mthi_stall", stall_o, 0);
    tick();
    drv(3'b110, 3'b000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1 n = 0;
    while (stall_o && n < 5) begin n++; tick(); end
    chk("mfhi_stall_cycles", n, BYP ? 2 - 2 : 2);
    chk("mfhi_hi_e", hi_e, 32'h12345678);
    tick();
    nop();
    tick();
    chk("mthi_hi_o", hi_o, 32'h12345678);
    chk("mthi_lo_o", lo_o, 0);
    // MULT, MTLO, MFLO
    drv(3'b000, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(3'b000, 3'b101, 1'b0, '0, 32'h5, 1'b0, 1'b0, 1'b0);
    tick();
    drv(3'b101, 3'b000, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1 n = 0;
    while (stall_o && n < 5) begin n++; tick(); end
    chk("mflo_stall_cycles", n, BYP ? 0 : 2);
    chk("mflo_lo_e", lo_e, 32'h5);
    chk("mflo_hi_e", hi_e, 32'hFFFFFFFF);
    tick();
    nop();
    tick(); tick();
    chk("b2b_hi_o", hi_o, 32'hFFFFFFFF);
    chk("b2b_lo_o", lo_o, 32'h5);
    // DIV with done on the 8th busy cycle
    st_cycles = 0; starts = 0; aborts = 0;
    for (int c = 0; c < 10; c++) begin
      drv(3'b000, 3'b111, 1'b1, c >= 8 ? 32'h3 : 32'h0, c >= 8 ? 32'h7 : 32'h0, c == 8, 1'b0, 1'b0);
      #1;
      st_cycles += int'(stall_o);
      starts += int'(div_start);
      aborts += int'(div_abort);
      tick();
    end
    chk("div_stall_cycles", st_cycles, 9);
    chk("div_start_pulses", starts, 1);
    chk("div_abort_pulses", aborts, 0);
    nop();
    tick(); tick();
    chk("div_hi_o", hi_o, 32'h3);
    chk("div_lo_o", lo_o, 32'h7);
    // flush three cycles after launch
    aborts = 0; starts = 0;
    for (int c = 0; c < 5; c++) begin
      drv(3'b000, c < 4 ? 3'b111 : 3'b000, c < 4, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, c == 3);
      #1;
      aborts += int'(div_abort);
      starts += int'(div_start);
      if (c == 3) chk("flush_busy_stall", stall_o, 1);
      if (c == 4) chk("flush_stall_drop", stall_o, 0);
      tick();
    end
    chk("flush_abort_pulses", aborts, 1);
    chk("flush_start_pulses", starts, 1);
    nop();
    tick(); tick();
    chk("flush_hi_o", hi_o, 32'h3);
    chk("flush_lo_o", lo_o, 32'h7);
    // flush together with a DIV in IDLE: no launch, nothing written
    drv(3'b000, 3'b111, 1'b1, 32'hAA, 32'hBB, 1'b0, 1'b0, 1'b1);
    #1;
    chk("flush_idle_start", div_start, 0);
    chk("flush_idle_stall", stall_o, 0);
    tick();
    nop();
    #1 chk("flush_idle_after", stall_o, 0);
    tick(); tick();
    chk("flush_idle_hi_o", hi_o, 32'h3);
    chk("flush_idle_lo_o", lo_o, 32'h7);
    // external stall with MTLO in M
    drv(3'b000, 3'b101, 1'b0, '0, 32'hABCD, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      drv(3'b000, 3'b000, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      #1 chk("stall_lo_o_hold", lo_o, 32'h7);
      tick();
    end
    nop();
    tick();
    chk("stall_lo_o_adv1", lo_o, 32'h7);
    tick();
    chk("stall_lo_o_adv2", lo_o, 32'hABCD);
    // DIV with stall_i while BUSY and while DONE
    drv(3'b000, 3'b111, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(3'b000, 3'b111, 1'b1, 32'h9, 32'hA, 1'b1, 1'b1, 1'b0);
    #1 chk("busy_stalli_stall", stall_o, 1);
    tick();
    drv(3'b000, 3'b111, 1'b1, 32'h9, 32'hA, 1'b0, 1'b1, 1'b0);
    #1;
    chk("done_stalli_stall", stall_o, 0);
    chk("done_stalli_start", div_start, 0);
    tick();
    drv(3'b000, 3'b111, 1'b1, 32'h9, 32'hA, 1'b0, 1'b0, 1'b0);
    #1 chk("done_release_start", div_start, 0);
    tick();
    nop();
    tick(); tick();
    chk("div2_hi_o", hi_o, 32'h9);
    chk("div2_lo_o", lo_o, 32'hA);
    // reset in the middle of a divide
    drv(3'b000, 3'b111, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    #1 chk("mid_div_busy", stall_o, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_abort", div_abort, 0);
    chk("mid_rst_hi_o", hi_o, 0);
    chk("mid_rst_lo_o", lo_o, 0);
    tick();
    resetn = 1'b1;
    tick();
    // randomized stream against the pending-write queue model
    mhi = '0; mlo = '0; q.delete();
    new_instr();
    for (int c = 0; c < 400; c++) begin
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 19) == 0);
      drv(cf1, cf2, 1'b0, chw, clw, 1'b0, st, fl);
      #1;
      ehi = mhi; elo = mlo; est = 1'b0;
      foreach (q[i]) begin
        if (BYP && q[i].mask[1]) ehi = q[i].hi;
        if (BYP && q[i].mask[0]) elo = q[i].lo;
        if (!BYP && cf1[2] && |(q[i].mask & cf1[1:0])) est = 1'b1;
      end
      chk("r_hi_e", hi_e, ehi);
      chk("r_lo_e", lo_e, elo);
      chk("r_stall", stall_o, est);
      chk("r_hi_o", hi_o, mhi);
      chk("r_lo_o", lo_o, mlo);
      chk("r_start", div_start, 0);
      tick();
      if (!st) begin
        foreach (q[i]) q[i].left--;
        if (q.size() > 0 && q[0].left == 0) begin
          if (q[0].mask[1]) mhi = q[0].hi;
          if (q[0].mask[0]) mlo = q[0].lo;
          void'(q.pop_front());
        end
        if (cf2[2] && !fl && !est) q.push_back('{cf2[1:0], chw, clw, 2});
        if (!est || fl) new_instr();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
